// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap sequencer for the 5-stage RV32I pipeline.
//
// Accepts an illegal-instruction exception from decode, an mret, and one
// level-sensitive external interrupt.  A request accepted in IDLE drains the
// older instructions (DRAIN), updates the M-mode trap CSRs (COMMIT), then
// redirects fetch to mtvec or mepc (REDIRECT) before returning to IDLE.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   exc_valid/cause/pc/tval     decode-stage exception request
//   mret_valid                  mret decoded in D
//   irq_ext, irq_pc             level external interrupt, PC of instr in D
//   csr_we/addr/wdata           software CSR write port (honoured in IDLE only)
//   csr_rdata                   combinational CSR read data
//   stallF, stallD              hold PC / F-D register
//   flushD, flushE              clear F-D / D-E register
//   redir_valid, redir_pc       one-cycle fetch redirect strobe and target
//   trap_busy                   high whenever the sequencer is not IDLE
module trap_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0100,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            trap_busy
);

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIR} state_t;
  typedef enum logic [1:0] {K_EXC, K_RET, K_IRQ} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_meie_q, mie_meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic            stall_f_q, stall_f_d;
  logic            stall_d_q, stall_d_d;
  logic            flush_d_q, flush_d_d;
  logic            flush_e_q, flush_e_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    redir_pc_d     = redir_pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (csr_we) begin
          unique case (csr_addr)
            12'h300: begin
              mstatus_mie_d  = csr_wdata[3];
              mstatus_mpie_d = csr_wdata[7];
            end
            12'h304: mie_meie_d = csr_wdata[11];
            12'h305: mtvec_d    = {csr_wdata[XLEN-1:2], 2'b00};
            12'h341: mepc_d     = {csr_wdata[XLEN-1:2], 2'b00};
            12'h342: mcause_d   = csr_wdata;
            12'h343: mtval_d    = csr_wdata;
            default: ;
          endcase
        end
        // Priority exc > mret > irq; the interrupt uses the pre-write enables.
        if (exc_valid) begin
          kind_d  = K_EXC;
          pc_d    = exc_pc;
          cause_d = exc_cause;
          tval_d  = exc_tval;
          state_d = S_DRAIN;
          cnt_d   = CNT_INIT;
        end else if (mret_valid) begin
          kind_d  = K_RET;
          state_d = S_DRAIN;
          cnt_d   = CNT_INIT;
        end else if (irq_ext && mstatus_mie_q && mie_meie_q) begin
          kind_d  = K_IRQ;
          pc_d    = irq_pc;
          state_d = S_DRAIN;
          cnt_d   = CNT_INIT;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 4'd0) state_d = S_COMMIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_COMMIT: begin
        state_d = S_REDIR;
        unique case (kind_q)
          K_EXC: begin
            mepc_d         = pc_q;
            mcause_d       = {{(XLEN-5){1'b0}}, cause_q};
            mtval_d        = tval_q;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            redir_pc_d     = mtvec_q;
          end
          K_IRQ: begin
            mepc_d         = pc_q;
            mcause_d       = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
            mtval_d        = '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            redir_pc_d     = mtvec_q;
          end
          default: begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            redir_pc_d     = mepc_q;
          end
        endcase
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    stall_f_d     = (state_d == S_DRAIN) || (state_d == S_COMMIT);
    stall_d_d     = (state_d == S_DRAIN) || (state_d == S_COMMIT);
    flush_e_d     = (state_d != S_IDLE);
    flush_d_d     = (state_d == S_REDIR);
    redir_valid_d = (state_d == S_REDIR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      kind_q         <= K_EXC;
      cnt_q          <= '0;
      pc_q           <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      stall_f_q      <= 1'b0;
      stall_d_q      <= 1'b0;
      flush_d_q      <= 1'b0;
      flush_e_q      <= 1'b0;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      cause_q        <= cause_d;
      tval_q         <= tval_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      stall_f_q      <= stall_f_d;
      stall_d_q      <= stall_d_d;
      flush_d_q      <= flush_d_d;
      flush_e_q      <= flush_e_d;
      redir_valid_q  <= redir_valid_d;
      redir_pc_q     <= redir_pc_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      12'h300: begin
        csr_rdata[3] = mstatus_mie_q;
        csr_rdata[7] = mstatus_mpie_q;
      end
      12'h304: csr_rdata[11] = mie_meie_q;
      12'h305: csr_rdata     = mtvec_q;
      12'h341: csr_rdata     = mepc_q;
      12'h342: csr_rdata     = mcause_q;
      12'h343: csr_rdata     = mtval_q;
      default: ;
    endcase
  end

  assign stallF      = stall_f_q;
  assign stallD      = stall_d_q;
  assign flushD      = flush_d_q;
  assign flushE      = flush_e_q;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign trap_busy   = (state_q != S_IDLE);

endmodule
